sprite_row_fetcher: RTL and testbench
=====================================

// Module: sprite_row_fetcher
// PURPOSE
//  Avalon-MM read master that drains one 16-pixel row of a 16x16 sprite from a
//  single-port sprite ROM (256 x 16-bit words, RGB565, row-major, 1-cycle read
//  latency) and emits it as a valid/ready pixel stream to the line-buffer writer.
//  Sits between the sprite ROM slave ports and the VGA line-buffer compositor;
//  one instance per sprite ROM.
// PARAMETERS
//  ADDR_W      8        ROM word-address width (256 words)
//  DATA_W      16       ROM / pixel data width
//  SPR_W       16       pixels per sprite row (power of 2); rows = 2**ADDR_W / SPR_W
//  FIFO_DEPTH  4        pixel skid FIFO entries (power of 2, >= 2)
//  TRANSP_KEY  16'h0000 colour treated as transparent
// PORTS
//  clk            in   1       system clock
//  reset_n        in   1       reset; asynchronous, active-low
//  start          in   1       1-cycle pulse: fetch row `row`
//  row            in   4       sprite row index, sampled on accepted start
//  x_base         in   10      screen x of sprite column 0, sampled on start
//  mirror         in   1       1 = horizontal flip, sampled on start
//  busy           out  1       high from accepted start until done
//  done           out  1       1-cycle pulse after last pixel accepted
//  rom_address    out  ADDR_W  ROM word address
//  rom_chipselect out  1       read strobe (ROM write/debugaccess tied 0 at top)
//  rom_clken      out  1       ROM clock enable
//  rom_readdata   in   DATA_W  ROM data, valid 1 cycle after strobed address
//  pix_valid      out  1       pixel stream valid
//  pix_ready      in   1       pixel stream ready from line-buffer writer
//  pix_data       out  DATA_W  RGB565 pixel
//  pix_x          out  10      screen x = x_base + col (mod 1024)
//  pix_opaque     out  1       pix_data != TRANSP_KEY
//  pix_last       out  1       final pixel of the row
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, pix_valid, rom_chipselect = 0; rom_address = 0;
//    rom_clken = 1; FIFO empty; issue/out counters = 0.
//  - FSM: IDLE -start-> FETCH (latch row, x_base, mirror; col_issue = 0).
//    FETCH: issue one read/cycle while (fifo_count + inflight) < FIFO_DEPTH;
//    after SPR_W issues -> DRAIN. DRAIN: when FIFO empty, no inflight and last
//    pixel accepted -> IDLE with done = 1 for one cycle.
//  - Address: rom_address = row*SPR_W + (mirror ? SPR_W-1-col_issue : col_issue),
//    registered; rom_chipselect asserted the same cycle. rom_clken held 1.
//  - Latency: rom_readdata captured into FIFO exactly 1 cycle after a strobed
//    issue (inflight flag); first pix_valid 2 cycles after start (earliest).
//  - Stream: pix_* are FIFO head, stable while pix_valid & !pix_ready; pop on
//    pix_valid & pix_ready. Simultaneous push+pop keeps count. Sustained
//    throughput 1 pixel/clk when pix_ready held high.
//  - pix_x = x_base + screen column index (0..SPR_W-1, independent of mirror);
//    10-bit wrap, no saturation. pix_last = (output index == SPR_W-1).
//  - start while busy is ignored (no queueing). start and done in same cycle:
//    done completes, start ignored (busy still 1 that cycle).
//  - FIFO never overflows by construction (credit check includes inflight read).
//  - reset_n low mid-row: immediate abort, all state to reset values, no done.
// STRUCTURE
//  - Shared package sprite_pkg: SPR_W, ROM ADDR_W/DATA_W, TRANSP_KEY default,
//    RGB565 typedef, state enum {IDLE, FETCH, DRAIN}.
//  - One sub-module: sprite_pix_fifo (sync FIFO, FIFO_DEPTH x (DATA_W+10+1) bits:
//    data, x, last; count output); opaque flag derived at output.
// TESTING
//  - ROM word k = 16'h1000+k; start row=3, x_base=100, pix_ready=1 -> 16 pixels
//    16'h1030..16'h103F, pix_x 100..115, pix_last on 16th, done 1 cycle later.
//  - Same with mirror=1 -> data 16'h103F..16'h1030, pix_x still 100..115.
//  - pix_ready toggled 1-0-1-0 -> no loss/duplication, rom reads stall at
//    FIFO_DEPTH outstanding, order preserved, held data stable while stalled.
//  - x_base=1020, row=0 -> pix_x 1020..1023 then 0..11 (wrap).
//  - ROM word 0x25 = 16'h0000, row=2 -> 6th pixel pix_opaque=0, others 1.
//  - reset_n low at pixel 7 -> outputs to reset values within same cycle, no done;
//    start after release -> full clean row; start during busy -> ignored.

Source files
------------

// File: rtl/sprite_row_fetcher_pkg.sv
// Shared widths, defaults and types for the sprite row fetcher.
package sprite_pkg;

    localparam int unsigned ROM_ADDR_W     = 8;
    localparam int unsigned ROM_DATA_W     = 16;
    localparam int unsigned SPR_ROW_W      = 16;
    localparam int unsigned PIX_FIFO_DEPTH = 4;
    localparam int unsigned X_W            = 10;

    localparam logic [ROM_DATA_W-1:0] TRANSP_KEY_DEF = 16'h0000;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Screen column with natural 10-bit wrap.
    function automatic logic [X_W-1:0] screen_x(input logic [X_W-1:0] base,
                                                 input logic [X_W-1:0] col);
        return base + col;
    endfunction

endpackage

// File: rtl/sprite_row_fetcher_if.sv
// ROM read port and pixel stream bundle between fetcher, sprite ROM and line-buffer writer.
interface sprite_row_fetcher_if
    import sprite_pkg::*;
#(
    parameter int unsigned ADDR_W = ROM_ADDR_W,
    parameter int unsigned DATA_W = ROM_DATA_W
);
    logic [ADDR_W-1:0] rom_address;
    logic              rom_chipselect;
    logic              rom_clken;
    logic [DATA_W-1:0] rom_readdata;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic [X_W-1:0]    pix_x;
    logic              pix_opaque;
    logic              pix_last;

    modport master (
        output rom_address, rom_chipselect, rom_clken,
        input  rom_readdata,
        output pix_valid, pix_data, pix_x, pix_opaque, pix_last,
        input  pix_ready
    );

    modport slave (
        input  rom_address, rom_chipselect, rom_clken,
        output rom_readdata,
        input  pix_valid, pix_data, pix_x, pix_opaque, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/sprite_pix_fifo.sv
// Small synchronous skid FIFO holding {pixel, screen x, last} entries with occupancy count.
module sprite_pix_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 27
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) rd_q <= rd_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row from the ROM (optionally mirrored) and streams it as
// x-tagged pixels; reads are credit-limited so the skid FIFO can never overflow.
module sprite_row_fetcher
    import sprite_pkg::*;
#(
    parameter int unsigned      ADDR_W     = ROM_ADDR_W,
    parameter int unsigned      DATA_W     = ROM_DATA_W,
    parameter int unsigned      SPR_W      = SPR_ROW_W,
    parameter int unsigned      FIFO_DEPTH = PIX_FIFO_DEPTH,
    parameter logic [DATA_W-1:0] TRANSP_KEY = TRANSP_KEY_DEF
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [ADDR_W-$clog2(SPR_W)-1:0]   row,
    input  logic [X_W-1:0]                    x_base,
    input  logic                              mirror,
    output logic                              busy,
    output logic                              done,
    sprite_row_fetcher_if.master              bus
);
    localparam int unsigned COL_W = $clog2(SPR_W);
    localparam int unsigned ROW_W = ADDR_W - COL_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OUT_W = CNT_W + 1;
    localparam int unsigned ENT_W = DATA_W + X_W + 1;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [X_W-1:0]    xb_q, xb_d;
    logic              mir_q, mir_d;
    logic [COL_W-1:0]  col_issue_q, col_issue_d;
    logic [COL_W-1:0]  col_push_q, col_push_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              issue_c;
    logic [ROW_W-1:0]  issue_row_c;
    logic              issue_mir_c;
    logic [COL_W-1:0]  issue_col_c;
    logic [OUT_W-1:0]  outstanding_c;
    logic              credit_ok_c;
    logic              push_c;
    logic              pop_c;
    logic [ENT_W-1:0]  push_data_c;
    logic [ENT_W-1:0]  head_c;
    logic [CNT_W-1:0]  fifo_count_c;
    logic [DATA_W-1:0] head_data_c;
    logic [X_W-1:0]    head_x_c;
    logic              head_last_c;

    // Each outstanding read (strobed or returning) already owns a FIFO slot.
    assign outstanding_c = OUT_W'(fifo_count_c) + OUT_W'(cs_q) + OUT_W'(pend_q);
    assign credit_ok_c   = outstanding_c < OUT_W'(FIFO_DEPTH);

    assign push_c      = pend_q;
    assign push_data_c = {bus.rom_readdata,
                          screen_x(xb_q, X_W'(col_push_q)),
                          col_push_q == COL_W'(SPR_W - 1)};

    sprite_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_c),
        .data_i  (push_data_c),
        .pop_i   (pop_c),
        .head_o  (head_c),
        .count_o (fifo_count_c)
    );

    assign {head_data_c, head_x_c, head_last_c} = head_c;
    assign pop_c = bus.pix_valid && bus.pix_ready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        xb_d        = xb_q;
        mir_d       = mir_q;
        col_issue_d = col_issue_q;
        col_push_d  = col_push_q;
        addr_d      = addr_q;
        cs_d        = 1'b0;
        pend_d      = cs_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        issue_c     = 1'b0;
        issue_row_c = row_q;
        issue_mir_c = mir_q;
        issue_col_c = col_issue_q;

        if (done_q) busy_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // busy_q is still set during the done cycle, which blocks a coincident start.
                if (start && !busy_q) begin
                    row_d       = row;
                    xb_d        = x_base;
                    mir_d       = mirror;
                    busy_d      = 1'b1;
                    col_push_d  = '0;
                    issue_c     = 1'b1;
                    issue_row_c = row;
                    issue_mir_c = mirror;
                    issue_col_c = '0;
                    col_issue_d = COL_W'(1);
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (credit_ok_c) begin
                    issue_c     = 1'b1;
                    col_issue_d = col_issue_q + COL_W'(1);
                    if (col_issue_q == COL_W'(SPR_W - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_c && head_last_c) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_c) begin
            cs_d   = 1'b1;
            addr_d = {issue_row_c, issue_mir_c ? ~issue_col_c : issue_col_c};
        end
        if (push_c) col_push_d = col_push_q + COL_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            xb_q        <= '0;
            mir_q       <= 1'b0;
            col_issue_q <= '0;
            col_push_q  <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            xb_q        <= xb_d;
            mir_q       <= mir_d;
            col_issue_q <= col_issue_d;
            col_push_q  <= col_push_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign bus.rom_address    = addr_q;
    assign bus.rom_chipselect = cs_q;
    assign bus.rom_clken      = 1'b1;
    assign bus.pix_valid      = fifo_count_c != '0;
    assign bus.pix_data       = head_data_c;
    assign bus.pix_x          = head_x_c;
    assign bus.pix_last       = head_last_c;
    assign bus.pix_opaque     = head_data_c != TRANSP_KEY;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Scoreboard bench for sprite_row_fetcher: rows are predicted from a ROM image and
// checked by an independent pixel monitor.
module tb_sprite_row_fetcher;
    import sprite_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] row = '0;
    logic [9:0] x_base = '0;
    logic       mirror = 1'b0;
    logic       busy;
    logic       done;

    sprite_row_fetcher_if bus ();

    sprite_row_fetcher dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .row     (row),
        .x_base  (x_base),
        .mirror  (mirror),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [256];
    always @(posedge clk)
        if (bus.rom_chipselect && bus.rom_clken) bus.rom_readdata <= rom[bus.rom_address];

    typedef struct {
        logic [15:0] data;
        logic [9:0]  x;
        logic        opaque;
        logic        last;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    int   acc_row = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Ready pattern generator for the line-buffer side.
    initial begin
        bus.pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = ~bus.pix_ready;
                2:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expected pixels on handshake, checks hold, done timing and read credit.
    initial begin
        bit          exp_done;
        bit          held;
        logic [15:0] held_d;
        logic [9:0]  held_x;
        logic        held_l;
        int          issued;
        int          accepted;
        exp_t        e;
        exp_done = 0; held = 0; issued = 0; accepted = 0;
        held_d = '0; held_x = '0; held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_done = 0; held = 0; issued = 0; accepted = 0;
                continue;
            end
            if (done || exp_done) check("done_timing", 32'(done), 32'(exp_done));
            exp_done = 0;
            if (bus.rom_chipselect) begin
                issued++;
                check("reads_outstanding_le_depth", 32'(issued - accepted <= int'(DEPTH)), 32'd1);
            end
            if (held) begin
                check("hold_valid", 32'(bus.pix_valid), 32'd1);
                check("hold_data", 32'(bus.pix_data), 32'(held_d));
                check("hold_x", 32'(bus.pix_x), 32'(held_x));
                check("hold_last", 32'(bus.pix_last), 32'(held_l));
            end
            held = 0;
            if (bus.pix_valid && !bus.pix_ready) begin
                held = 1; held_d = bus.pix_data; held_x = bus.pix_x; held_l = bus.pix_last;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel act=%0h/x%0d req=none t=%0t",
                             bus.pix_data, bus.pix_x, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 32'(bus.pix_data), 32'(e.data));
                    check("pix_x", 32'(bus.pix_x), 32'(e.x));
                    check("pix_opaque", 32'(bus.pix_opaque), 32'(e.opaque));
                    check("pix_last", 32'(bus.pix_last), 32'(e.last));
                    if (e.last) exp_done = 1;
                end
                accepted++;
                acc_row++;
            end
        end
    end

    // Reference: screen column c shows ROM word row*16 + c (or 15-c mirrored).
    task automatic push_row(input int r, input int xb, input bit m);
        exp_t e;
        int   addr;
        for (int c = 0; c < 16; c++) begin
            addr     = r * 16 + (m ? 15 - c : c);
            e.data   = rom[addr];
            e.x      = 10'((xb + c) % 1024);
            e.opaque = (rom[addr] != 16'h0000);
            e.last   = (c == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse(input int r, input int xb, input bit m);
        @(posedge clk);
        #1;
        row = 4'(r); x_base = 10'(xb); mirror = m; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < 400), 32'd1);
        check({name, "_all_pixels"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_row(input string name, input int r, input int xb, input bit m);
        push_row(r, xb, m);
        pulse(r, xb, m);
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_idle(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
        check({name, "_chipselect"}, 32'(bus.rom_chipselect), 32'd0);
        check({name, "_address"}, 32'(bus.rom_address), 32'd0);
        check({name, "_clken"}, 32'(bus.rom_clken), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 256; k++) rom[k] = 16'h1000 + 16'(k);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        ready_mode = 0;
        run_row("row3", 3, 100, 1'b0);
        run_row("row3_mirror", 3, 100, 1'b1);

        ready_mode = 1;
        run_row("toggle_a", 5, 300, 1'b0);
        run_row("toggle_b", 9, 7, 1'b1);

        ready_mode = 0;
        run_row("xwrap", 0, 1020, 1'b0);

        rom[8'h25] = 16'h0000;
        run_row("transparent", 2, 500, 1'b0);
        rom[8'h25] = 16'h1025;

        // Long back-pressure: reads must stop at the FIFO credit limit.
        ready_mode = 3;
        push_row(12, 40, 1'b0);
        pulse(12, 40, 1'b0);
        repeat (20) @(posedge clk);
        ready_mode = 2;
        wait_idle("stalled");

        for (int i = 0; i < 8; i++)
            run_row("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)),
                    1'($urandom_range(0, 1)));

        // Start while busy and start in the done cycle are both dropped.
        ready_mode = 0;
        push_row(7, 64, 1'b0);
        pulse(7, 64, 1'b0);
        repeat (3) @(posedge clk);
        pulse(1, 0, 1'b1);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        row = 4'd4; x_base = 10'd0; mirror = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_on_done_ignored", 32'(busy), 32'd0);
        wait_idle("busy_start");

        // Asynchronous abort mid-row, then a clean row.
        ready_mode = 0;
        acc_row = 0;
        push_row(6, 200, 1'b1);
        pulse(6, 200, 1'b1);
        n = 0;
        while (acc_row < 7 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("reach_pixel7", 32'(acc_row >= 7), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        run_row("after_abort", 6, 200, 1'b1);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
